// File: rtl/dgcl_pkg.sv
// Shared types and default sizing for the DGCL DMA engine.
package dgcl_pkg;

    localparam int DGCL_NUM_CH     = 4;
    localparam int DGCL_DATA_W     = 128;
    localparam int DGCL_ADDR_W     = 40;
    localparam int DGCL_LEN_W      = 16;
    localparam int DGCL_FIFO_DEPTH = 16;
    localparam int DGCL_DPRAM_W    = 16;

    // Bytes carried by one beat at the default beat width.
    localparam int DGCL_BYTES_PER_BEAT = DGCL_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_DONE
    } dgcl_state_t;

    // Bytes per beat for an arbitrary beat width (DRAM address stride).
    function automatic int bytes_per_beat(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dgcl_fifo.sv
// Read-data buffer: synchronous first-word-fall-through FIFO. The array
// read is registered; a write landing on the next head slot is forwarded
// so the head word is visible exactly one cycle after its push.
module dgcl_fifo
    import dgcl_pkg::*;
#(
    parameter int DATA_W = DGCL_DATA_W,
    parameter int DEPTH  = DGCL_FIFO_DEPTH
) (
    input  logic              gemmini_clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count_reg;
    logic              wr_fire;
    logic              rd_fire;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    // A pop on a full FIFO frees the slot the push reuses; no bypass when empty.
    assign wr_fire = push && (!full || pop);
    assign rd_fire = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(rd_fire);
    assign rd_data = rd_data_reg;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge gemmini_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_reg + CNT_W'(wr_fire) - CNT_W'(rd_fire);
        end
    end

    // Storage write and registered head read with write-to-head forwarding.
    always_ff @(posedge gemmini_clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        if (wr_fire && (wr_ptr_reg == rd_ptr_next)) begin
            rd_data_reg <= wr_data;
        end else begin
            rd_data_reg <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/dgcl_dma_engine.sv
// Multi-channel DMA engine: round-robin arbitration between client
// channels, DRAM read command + buffered read data, and beat-by-beat
// DRAM writes streamed straight from the granted client.
module dgcl_dma_engine
    import dgcl_pkg::*;
#(
    parameter int NUM_CH     = DGCL_NUM_CH,
    parameter int DATA_W     = DGCL_DATA_W,
    parameter int ADDR_W     = DGCL_ADDR_W,
    parameter int LEN_W      = DGCL_LEN_W,
    parameter int FIFO_DEPTH = DGCL_FIFO_DEPTH
) (
    input  logic                           gemmini_clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              ch_req,
    input  logic [NUM_CH-1:0]              ch_wr,
    input  logic [NUM_CH*ADDR_W-1:0]       ch_dram_addr,
    input  logic [NUM_CH*DGCL_DPRAM_W-1:0] ch_dpram_addr,
    input  logic [NUM_CH*LEN_W-1:0]        ch_length,
    output logic [NUM_CH-1:0]              ch_resp,
    input  logic [NUM_CH-1:0]              ch_wdata_valid,
    input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
    output logic [NUM_CH-1:0]              ch_wdata_ready,
    output logic [NUM_CH-1:0]              ch_rdata_valid,
    output logic [DATA_W-1:0]              ch_rdata,
    input  logic [NUM_CH-1:0]              ch_rdata_ready,
    output logic [ADDR_W-1:0]              rcc_dram_addr,
    output logic [DGCL_DPRAM_W-1:0]        rcc_dpram_addr,
    output logic [LEN_W-1:0]               rcc_length,
    output logic                           rcc_valid,
    input  logic                           rcc_ready,
    input  logic [DATA_W-1:0]              rcd_read_data,
    input  logic                           rcd_valid,
    output logic                           rcd_ready,
    output logic [ADDR_W-1:0]              wcc_dram_addr,
    output logic [DGCL_DPRAM_W-1:0]        wcc_dpram_addr,
    output logic [LEN_W-1:0]               wcc_length,
    output logic [DATA_W-1:0]              wcc_write_data,
    output logic                           wcc_valid,
    input  logic                           wcc_ready
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DP_W = DGCL_DPRAM_W;
    localparam int BPB  = bytes_per_beat(DATA_W);

    // Per-channel views of the packed command and write-data buses.
    logic [ADDR_W-1:0] cmd_dram_addr [NUM_CH];
    logic [DP_W-1:0]   cmd_dpram_addr [NUM_CH];
    logic [LEN_W-1:0]  cmd_length [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign cmd_dram_addr[gi]  = ch_dram_addr[gi*ADDR_W +: ADDR_W];
            assign cmd_dpram_addr[gi] = ch_dpram_addr[gi*DP_W +: DP_W];
            assign cmd_length[gi]     = ch_length[gi*LEN_W +: LEN_W];
            assign wdata_arr[gi]      = ch_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    dgcl_state_t       state_reg;
    dgcl_state_t       state_next;
    logic [CH_W-1:0]   grant_reg;
    logic              lat_wr_reg;
    logic [ADDR_W-1:0] lat_dram_addr_reg;
    logic [DP_W-1:0]   lat_dpram_addr_reg;
    logic [LEN_W-1:0]  lat_len_reg;
    logic [LEN_W-1:0]  rcv_cnt_reg;
    logic [LEN_W-1:0]  dlv_cnt_reg;
    logic [LEN_W-1:0]  wr_beat_reg;

    logic              arb_found;
    logic [CH_W-1:0]   arb_pick;
    logic [CH_W-1:0]   arb_cand;
    int                arb_idx;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              wr_hs;

    dgcl_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .gemmini_clk (gemmini_clk),
        .reset       (reset),
        .push        (fifo_push),
        .wr_data     (rcd_read_data),
        .pop         (fifo_pop),
        .rd_data     (fifo_rdata),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_cand  = '0;
        arb_idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_idx = int'(grant_reg) + 1 + i;
            if (arb_idx >= NUM_CH) begin
                arb_idx = arb_idx - NUM_CH;
            end
            arb_cand = CH_W'(arb_idx);
            if (!arb_found && ch_req[arb_cand]) begin
                arb_found = 1'b1;
                arb_pick  = arb_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge gemmini_clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and all client/DRAM handshake outputs.
    always_comb begin
        state_next     = state_reg;
        rcc_valid      = 1'b0;
        rcc_dram_addr  = '0;
        rcc_dpram_addr = '0;
        rcc_length     = '0;
        rcd_ready      = 1'b0;
        wcc_valid      = 1'b0;
        wcc_dram_addr  = '0;
        wcc_dpram_addr = '0;
        wcc_length     = '0;
        wcc_write_data = '0;
        ch_resp        = '0;
        ch_wdata_ready = '0;
        ch_rdata_valid = '0;
        ch_rdata       = '0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        wr_hs          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arb_found) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (lat_len_reg == '0) begin
                    state_next = ST_DONE;
                end else if (lat_wr_reg) begin
                    state_next = ST_WR_DATA;
                end else begin
                    state_next = ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                rcc_valid      = 1'b1;
                rcc_dram_addr  = lat_dram_addr_reg;
                rcc_dpram_addr = lat_dpram_addr_reg;
                rcc_length     = lat_len_reg;
                if (rcc_ready) begin
                    state_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rcd_ready = (rcv_cnt_reg < lat_len_reg) && !fifo_full;
                fifo_push = rcd_ready && rcd_valid;
                if (!fifo_empty) begin
                    ch_rdata_valid[grant_reg] = 1'b1;
                    ch_rdata                  = fifo_rdata;
                    fifo_pop                  = ch_rdata_ready[grant_reg];
                end
                if (dlv_cnt_reg == lat_len_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_WR_DATA: begin
                wcc_valid      = ch_wdata_valid[grant_reg];
                wcc_write_data = wdata_arr[grant_reg];
                ch_wdata_ready[grant_reg] = wcc_ready;
                wcc_dram_addr  = lat_dram_addr_reg + ADDR_W'(wr_beat_reg) * ADDR_W'(BPB);
                wcc_dpram_addr = lat_dpram_addr_reg + DP_W'(wr_beat_reg);
                wcc_length     = lat_len_reg;
                wr_hs          = wcc_valid && wcc_ready;
                if (wr_hs && ((wr_beat_reg + LEN_W'(1)) == lat_len_reg)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ch_resp[grant_reg] = 1'b1;
                state_next         = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Grant/command latch and per-transfer beat counters.
    always_ff @(posedge gemmini_clk or posedge reset) begin
        if (reset) begin
            grant_reg          <= CH_W'(NUM_CH - 1);
            lat_wr_reg         <= 1'b0;
            lat_dram_addr_reg  <= '0;
            lat_dpram_addr_reg <= '0;
            lat_len_reg        <= '0;
            rcv_cnt_reg        <= '0;
            dlv_cnt_reg        <= '0;
            wr_beat_reg        <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_reg          <= arb_pick;
                        lat_wr_reg         <= ch_wr[arb_pick];
                        lat_dram_addr_reg  <= cmd_dram_addr[arb_pick];
                        lat_dpram_addr_reg <= cmd_dpram_addr[arb_pick];
                        lat_len_reg        <= cmd_length[arb_pick];
                        rcv_cnt_reg        <= '0;
                        dlv_cnt_reg        <= '0;
                        wr_beat_reg        <= '0;
                    end
                end
                ST_RD_DATA: begin
                    if (fifo_push) begin
                        rcv_cnt_reg <= rcv_cnt_reg + LEN_W'(1);
                    end
                    if (fifo_pop) begin
                        dlv_cnt_reg <= dlv_cnt_reg + LEN_W'(1);
                    end
                end
                ST_WR_DATA: begin
                    if (wr_hs) begin
                        wr_beat_reg <= wr_beat_reg + LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dgcl_dma_engine.sv
// Directed bench for dgcl_dma_engine: read, write with address wrap,
// zero-length, round-robin order, FIFO back-pressure and mid-transfer reset.
module tb_dgcl_dma_engine;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 40;
    localparam int LEN_W  = 16;

    logic                   gemmini_clk = 1'b0;
    logic                   reset;
    logic [NUM_CH-1:0]      ch_req;
    logic [NUM_CH-1:0]      ch_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_dram_addr;
    logic [NUM_CH*16-1:0]   ch_dpram_addr;
    logic [NUM_CH*LEN_W-1:0] ch_length;
    logic [NUM_CH-1:0]      ch_resp;
    logic [NUM_CH-1:0]      ch_wdata_valid;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]      ch_wdata_ready;
    logic [NUM_CH-1:0]      ch_rdata_valid;
    logic [DATA_W-1:0]      ch_rdata;
    logic [NUM_CH-1:0]      ch_rdata_ready;
    logic [ADDR_W-1:0]      rcc_dram_addr;
    logic [15:0]            rcc_dpram_addr;
    logic [LEN_W-1:0]       rcc_length;
    logic                   rcc_valid;
    logic                   rcc_ready;
    logic [DATA_W-1:0]      rcd_read_data;
    logic                   rcd_valid;
    logic                   rcd_ready;
    logic [ADDR_W-1:0]      wcc_dram_addr;
    logic [15:0]            wcc_dpram_addr;
    logic [LEN_W-1:0]       wcc_length;
    logic [DATA_W-1:0]      wcc_write_data;
    logic                   wcc_valid;
    logic                   wcc_ready;

    dgcl_dma_engine dut (
        .gemmini_clk    (gemmini_clk),
        .reset          (reset),
        .ch_req         (ch_req),
        .ch_wr          (ch_wr),
        .ch_dram_addr   (ch_dram_addr),
        .ch_dpram_addr  (ch_dpram_addr),
        .ch_length      (ch_length),
        .ch_resp        (ch_resp),
        .ch_wdata_valid (ch_wdata_valid),
        .ch_wdata       (ch_wdata),
        .ch_wdata_ready (ch_wdata_ready),
        .ch_rdata_valid (ch_rdata_valid),
        .ch_rdata       (ch_rdata),
        .ch_rdata_ready (ch_rdata_ready),
        .rcc_dram_addr  (rcc_dram_addr),
        .rcc_dpram_addr (rcc_dpram_addr),
        .rcc_length     (rcc_length),
        .rcc_valid      (rcc_valid),
        .rcc_ready      (rcc_ready),
        .rcd_read_data  (rcd_read_data),
        .rcd_valid      (rcd_valid),
        .rcd_ready      (rcd_ready),
        .wcc_dram_addr  (wcc_dram_addr),
        .wcc_dpram_addr (wcc_dpram_addr),
        .wcc_length     (wcc_length),
        .wcc_write_data (wcc_write_data),
        .wcc_valid      (wcc_valid),
        .wcc_ready      (wcc_ready)
    );

    always #5 gemmini_clk = ~gemmini_clk;

    int errors = 0;
    int checks = 0;

    // Transaction log, sampled on the falling edge (handshake completes at next rise).
    logic [DATA_W-1:0] rx_q[$];
    int                rx_ch_q[$];
    int                resp_q[$];
    int                resp_cnt[NUM_CH];
    int                rcc_hs = 0;
    int                rcc_vcyc = 0;
    int                wcc_vcyc = 0;
    int                rcd_hs = 0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [15:0]       wd_q[$];
    logic [DATA_W-1:0] wdat_q[$];
    logic [LEN_W-1:0]  wl_q[$];

    initial begin
        for (int k = 0; k < NUM_CH; k++) resp_cnt[k] = 0;
    end

    always @(negedge gemmini_clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_rdata_valid[k] && ch_rdata_ready[k]) begin
                    rx_q.push_back(ch_rdata);
                    rx_ch_q.push_back(k);
                    $display("rdata  ch=%0d data=%h", k, ch_rdata);
                end
                if (ch_resp[k]) begin
                    resp_q.push_back(k);
                    resp_cnt[k] = resp_cnt[k] + 1;
                    $display("resp   ch=%0d", k);
                end
            end
            if (rcc_valid) rcc_vcyc = rcc_vcyc + 1;
            if (rcc_valid && rcc_ready) begin
                rcc_hs = rcc_hs + 1;
                $display("rcc    addr=%h dpram=%h len=%0d", rcc_dram_addr, rcc_dpram_addr, rcc_length);
            end
            if (rcd_valid && rcd_ready) begin
                rcd_hs = rcd_hs + 1;
                $display("rcd    data=%h", rcd_read_data);
            end
            if (wcc_valid) wcc_vcyc = wcc_vcyc + 1;
            if (wcc_valid && wcc_ready) begin
                wa_q.push_back(wcc_dram_addr);
                wd_q.push_back(wcc_dpram_addr);
                wdat_q.push_back(wcc_write_data);
                wl_q.push_back(wcc_length);
                $display("wcc    addr=%h dpram=%h len=%0d data=%h", wcc_dram_addr, wcc_dpram_addr, wcc_length, wcc_write_data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge gemmini_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [15:0] dp, input logic [LEN_W-1:0] len);
        ch_wr[ch] = wr;
        ch_dram_addr[ch*ADDR_W +: ADDR_W] = addr;
        ch_dpram_addr[ch*16 +: 16] = dp;
        ch_length[ch*LEN_W +: LEN_W] = len;
    endtask

    task automatic wait_rcc(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rcc_valid) begin ok = 1'b1; break; end
            step();
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic rcc_accept();
        rcc_ready = 1'b1;
        step();
        rcc_ready = 1'b0;
    endtask

    task automatic send_rcd(input logic [DATA_W-1:0] data, input string tag);
        logic ok;
        ok = 1'b0;
        rcd_valid = 1'b1;
        rcd_read_data = data;
        for (int i = 0; i < 60; i++) begin
            if (rcd_ready) begin step(); ok = 1'b1; break; end
            step();
        end
        rcd_valid = 1'b0;
        check(tag, ok, 1'b1);
    endtask

    task automatic send_wdata(input int ch, input logic [DATA_W-1:0] data, input string tag);
        logic ok;
        ok = 1'b0;
        ch_wdata[ch*DATA_W +: DATA_W] = data;
        ch_wdata_valid[ch] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (ch_wdata_ready[ch]) begin step(); ok = 1'b1; break; end
            step();
        end
        ch_wdata_valid[ch] = 1'b0;
        check(tag, ok, 1'b1);
    endtask

    // Waits for the completion pulse, then steps once so the FSM is back in IDLE.
    task automatic wait_resp(input int ch, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (ch_resp[ch]) begin ok = 1'b1; break; end
            step();
        end
        step();
        check(tag, ok, 1'b1);
    endtask

    logic [DATA_W-1:0] exp_d;
    int base_a;
    int base_b;
    int base_c;
    int bad;

    initial begin
        reset = 1'b1;
        ch_req = '0; ch_wr = '0; ch_dram_addr = '0; ch_dpram_addr = '0; ch_length = '0;
        ch_wdata_valid = '0; ch_wdata = '0; ch_rdata_ready = '0;
        rcc_ready = 1'b0; rcd_read_data = '0; rcd_valid = 1'b0; wcc_ready = 1'b0;

        // ---- reset state ----
        step(); step(); step();
        check("rst_handshakes", {rcc_valid, wcc_valid, rcd_ready, ch_resp, ch_rdata_valid, ch_wdata_ready}, '0);
        check("rst_addrs", {rcc_dram_addr, wcc_dram_addr, rcc_length, wcc_length}, '0);
        check("rst_data", ch_rdata | wcc_write_data, '0);
        reset = 1'b0;
        step();

        // ---- ch1 read, len 4 ----
        set_cmd(1, 1'b0, 40'h10_0000_0000, 16'h0020, 16'd4);
        ch_req[1] = 1'b1;
        wait_rcc("rd4_rcc_seen");
        check("rd4_rcc_addr", rcc_dram_addr, 40'h10_0000_0000);
        check("rd4_rcc_dpram", rcc_dpram_addr, 16'h0020);
        check("rd4_rcc_len", rcc_length, 16'd4);
        ch_req[1] = 1'b0;
        ch_rdata_ready[1] = 1'b1;
        base_a = rx_q.size();
        rcc_accept();
        check("rd4_empty_valid", ch_rdata_valid, 4'b0000);
        send_rcd(128'hA0A0_0000_0000_0000_0000_0000_0000_0000, "rd4_rcd0");
        check("rd4_lat_valid", ch_rdata_valid, 4'b0010);
        check("rd4_lat_data", ch_rdata, 128'hA0A0_0000_0000_0000_0000_0000_0000_0000);
        for (int k = 1; k < 4; k++) begin
            exp_d = 128'hA0A0_0000_0000_0000_0000_0000_0000_0000 + 128'(k);
            send_rcd(exp_d, "rd4_rcd");
        end
        wait_resp(1, "rd4_resp_seen");
        step();
        check("rd4_rcc_count", rcc_hs, 1);
        check("rd4_beats", rx_q.size() - base_a, 4);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            exp_d = 128'hA0A0_0000_0000_0000_0000_0000_0000_0000 + 128'(k);
            if (base_a + k >= rx_q.size() || rx_q[base_a + k] !== exp_d || rx_ch_q[base_a + k] != 1) bad++;
        end
        check("rd4_order", bad, 0);
        check("rd4_resp_once", resp_cnt[1], 1);
        ch_rdata_ready[1] = 1'b0;

        // ---- ch2 write, len 3, DRAM and dpram address wrap ----
        set_cmd(2, 1'b1, 40'hFF_FFFF_FFF0, 16'hFFFE, 16'd3);
        ch_req[2] = 1'b1;
        wcc_ready = 1'b1;
        base_a = wa_q.size();
        send_wdata(2, 128'hB000_0000_0000_0000_0000_0000_0000_0000, "wr3_beat0");
        check("wr3_other_ready", ch_wdata_ready, 4'b0100);
        ch_req[2] = 1'b0;
        send_wdata(2, 128'hB000_0000_0000_0000_0000_0000_0000_0001, "wr3_beat1");
        send_wdata(2, 128'hB000_0000_0000_0000_0000_0000_0000_0002, "wr3_beat2");
        wait_resp(2, "wr3_resp_seen");
        wcc_ready = 1'b0;
        check("wr3_beats", wa_q.size() - base_a, 3);
        if (wa_q.size() - base_a >= 3) begin
            check("wr3_addr0", wa_q[base_a],     40'hFF_FFFF_FFF0);
            check("wr3_addr1", wa_q[base_a + 1], 40'h00_0000_0000);
            check("wr3_addr2", wa_q[base_a + 2], 40'h00_0000_0010);
            check("wr3_dpram", {wd_q[base_a], wd_q[base_a + 1], wd_q[base_a + 2]}, 48'hFFFE_FFFF_0000);
            check("wr3_data2", wdat_q[base_a + 2], 128'hB000_0000_0000_0000_0000_0000_0000_0002);
            check("wr3_len", wl_q[base_a], 16'd3);
        end
        check("wr3_resp_once", resp_cnt[2], 1);

        // ---- zero-length request on ch3 ----
        base_b = rcc_vcyc;
        base_c = wcc_vcyc;
        set_cmd(3, 1'b0, 40'h00_0000_0055, 16'h0001, 16'd0);
        ch_req[3] = 1'b1;
        step();
        check("zl_resp_c1", ch_resp, 4'b0000);
        step();
        check("zl_resp_c2", ch_resp, 4'b1000);
        ch_req[3] = 1'b0;
        step();
        check("zl_resp_c3", ch_resp, 4'b0000);
        check("zl_no_rcc", rcc_vcyc - base_b, 0);
        check("zl_no_wcc", wcc_vcyc - base_c, 0);

        // ---- round robin with all requests held ----
        for (int k = 0; k < NUM_CH; k++) set_cmd(k, 1'b0, 40'h0, 16'h0, 16'd0);
        base_a = resp_q.size();
        ch_req = 4'hF;
        for (int i = 0; i < 60; i++) begin
            step();
            if (resp_q.size() - base_a >= 5) break;
        end
        ch_req = 4'h0;
        check("rr_count", resp_q.size() - base_a, 5);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (base_a + i >= resp_q.size() || resp_q[base_a + i] != (i % 4)) bad++;
        end
        check("rr_order", bad, 0);
        step();

        // ---- ch0 read len 20 with client back-pressure ----
        set_cmd(0, 1'b0, 40'h00_1234_5000, 16'h0100, 16'd20);
        ch_req[0] = 1'b1;
        wait_rcc("rd20_rcc_seen");
        check("rd20_rcc_len", rcc_length, 16'd20);
        ch_req[0] = 1'b0;
        base_a = rx_q.size();
        base_b = rcd_hs;
        rcc_accept();
        for (int k = 0; k < 16; k++) send_rcd(128'hC0DE_0000_0000_0000_0000_0000_0000_0000 + 128'(k), "rd20_fill");
        rcd_valid = 1'b1;
        rcd_read_data = 128'hC0DE_0000_0000_0000_0000_0000_0000_0010;
        step(); step();
        check("rd20_stall_ready", rcd_ready, 1'b0);
        check("rd20_stall_count", rcd_hs - base_b, 16);
        check("rd20_stall_valid", ch_rdata_valid, 4'b0001);
        rcd_valid = 1'b0;
        ch_rdata_ready[0] = 1'b1;
        for (int k = 16; k < 20; k++) send_rcd(128'hC0DE_0000_0000_0000_0000_0000_0000_0000 + 128'(k), "rd20_resume");
        wait_resp(0, "rd20_resp_seen");
        step();
        check("rd20_beats", rx_q.size() - base_a, 20);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            exp_d = 128'hC0DE_0000_0000_0000_0000_0000_0000_0000 + 128'(k);
            if (base_a + k >= rx_q.size() || rx_q[base_a + k] !== exp_d) bad++;
        end
        check("rd20_order", bad, 0);
        ch_rdata_ready[0] = 1'b0;

        // ---- reset while in RD_DATA ----
        set_cmd(1, 1'b0, 40'hAB_0000_0000, 16'h0000, 16'd4);
        ch_req[1] = 1'b1;
        wait_rcc("rst_rcc_seen");
        ch_req[1] = 1'b0;
        rcc_accept();
        send_rcd(128'hDEAD_0000_0000_0000_0000_0000_0000_0001, "rst_rcd0");
        send_rcd(128'hDEAD_0000_0000_0000_0000_0000_0000_0002, "rst_rcd1");
        base_c = resp_cnt[1];
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_handshakes", {rcc_valid, wcc_valid, rcd_ready, ch_resp, ch_rdata_valid, ch_wdata_ready}, '0);
        check("rst_mid_data", ch_rdata, '0);
        step(); step();
        reset = 1'b0;
        step();
        set_cmd(0, 1'b0, 40'h0F_0000_0040, 16'h0010, 16'd1);
        ch_req[0] = 1'b1;
        wait_rcc("post_rcc_seen");
        check("post_rcc_addr", rcc_dram_addr, 40'h0F_0000_0040);
        ch_req[0] = 1'b0;
        ch_rdata_ready[0] = 1'b1;
        base_a = rx_q.size();
        rcc_accept();
        send_rcd(128'hF00D_0000_0000_0000_0000_0000_0000_0000, "post_rcd0");
        wait_resp(0, "post_resp_seen");
        step();
        check("post_beats", rx_q.size() - base_a, 1);
        if (rx_q.size() > base_a) check("post_data", rx_q[base_a], 128'hF00D_0000_0000_0000_0000_0000_0000_0000);
        check("post_no_stale_resp", resp_cnt[1], base_c);
        ch_rdata_ready[0] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dgcl_dma_engine.md
DGCL_DMA_ENGINE -- requirements
Module: dgcl_dma_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA client channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 128, beat width in bits.
REQ-003 SHALL have parameter ADDR_W, default 40, DRAM byte-address width.
REQ-004 SHALL have parameter LEN_W, default 16, transfer length in beats.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, read-data FIFO depth (power of 2).
REQ-006 SHALL have port gemmini_clk, in, 1, sole clock.
REQ-007 SHALL have port reset, in, 1, reset: asynchronous, active-high.
REQ-008 SHALL have ports ch_req / ch_wr, in, NUM_CH each, per-channel request level and direction (1 = write to DRAM).
REQ-009 SHALL have ports ch_dram_addr / ch_dpram_addr / ch_length, in, NUM_CH*ADDR_W / NUM_CH*16 / NUM_CH*LEN_W, packed per-channel command.
REQ-010 SHALL have port ch_resp, out, NUM_CH, one-cycle completion pulse.
REQ-011 SHALL have ports ch_wdata_valid in NUM_CH, ch_wdata in NUM_CH*DATA_W, ch_wdata_ready out NUM_CH, client write stream.
REQ-012 SHALL have ports ch_rdata_valid out NUM_CH, ch_rdata out DATA_W (shared), ch_rdata_ready in NUM_CH, client read stream.
REQ-013 SHALL have ports rcc_dram_addr out ADDR_W, rcc_dpram_addr out 16, rcc_length out LEN_W, rcc_valid out, rcc_ready in, DRAM read command.
REQ-014 SHALL have ports rcd_read_data in DATA_W, rcd_valid in, rcd_ready out, DRAM read data.
REQ-015 SHALL have ports wcc_dram_addr out ADDR_W, wcc_dpram_addr out 16, wcc_length out LEN_W, wcc_write_data out DATA_W, wcc_valid out, wcc_ready in, DRAM write beat.

Function
REQ-016 SHALL transfer on any valid/ready pair high at a gemmini_clk rising edge; a valid, once raised, holds its payload until accepted.
REQ-017 SHALL run FSM states IDLE, GRANT, RD_CMD, RD_DATA, WR_DATA, DONE.
REQ-018 SHALL in IDLE grant the first ch_req set, searching round-robin from (last grant + 1) mod NUM_CH; latch command; go to GRANT next cycle.
REQ-019 SHALL in GRANT go to DONE if latched length = 0 (no DRAM traffic), else RD_CMD (ch_wr=0) or WR_DATA (ch_wr=1).
REQ-020 SHALL in RD_CMD assert rcc_valid with latched addr/dpram/length; on handshake go to RD_DATA.
REQ-021 SHALL in RD_DATA assert rcd_ready only while beats_received < length and FIFO not full; push accepted beats into FIFO.
REQ-022 SHALL drive ch_rdata_valid only on the granted channel while the FIFO is non-empty; leave FIFO data on ch_rdata with 1-cycle latency from push.
REQ-023 SHALL go RD_DATA -> DONE when beats_delivered = length.
REQ-024 SHALL in WR_DATA route granted ch_wdata/valid to wcc_write_data/wcc_valid and wcc_ready to ch_wdata_ready (combinational); other channels' ready = 0.
REQ-025 SHALL drive wcc_dram_addr = base + beat_index*(DATA_W/8), wcc_dpram_addr = dpram base + beat_index, wcc_length = total length.
REQ-026 SHALL go WR_DATA -> DONE after the length-th beat handshake.
REQ-027 SHALL in DONE pulse ch_resp[grant] for exactly one cycle, then return to IDLE.
REQ-028 SHALL wrap DRAM address modulo 2^ADDR_W and dpram address modulo 2^16 without error.
REQ-029 SHALL ignore ch_req changes of non-granted channels mid-transfer; a granted channel dropping ch_req does not abort the transfer.
REQ-030 SHALL accept FIFO push and pop in the same cycle when full (pop frees slot) and when empty (no bypass; data appears next cycle).

Reset
REQ-031 SHALL on reset return FSM to IDLE, clear counters, FIFO pointers, and set the last-grant pointer to NUM_CH-1 (channel 0 first).
REQ-032 SHALL hold all valid/ready/resp outputs at 0 and addr/length/data outputs at 0 during reset; reset mid-transfer discards it with no resp.

Structure
REQ-033 SHALL place the FSM state enum, the default widths, and the bytes-per-beat constant in package dgcl_pkg.
REQ-034 SHALL implement the read-data buffer as sub-module dgcl_fifo (synchronous, DATA_W x FIFO_DEPTH, full/empty flags).

Verification
REQ-035 SHALL cover: ch1 read, addr 0x10_0000_0000, len 4, rcd 4 beats -> one rcc handshake with length 4, 4 ch_rdata beats in order, ch_resp[1] pulse once.
REQ-036 SHALL cover: ch2 write len 3, base 0xFF_FFFF_FFF0 -> wcc_dram_addr 0xFF_FFFF_FFF0, 0x0, 0x10; then resp[2].
REQ-037 SHALL cover: all four ch_req held -> grants 0,1,2,3,0 in order.
REQ-038 SHALL cover: read len 20, ch_rdata_ready low -> rcd_ready drops after 16 beats; resumes after pops; all 20 delivered.
REQ-039 SHALL cover: length 0 request -> no rcc/wcc valid, ch_resp pulse 2 cycles after grant.
REQ-040 SHALL cover: reset asserted in RD_DATA -> outputs 0 immediately, next request starts cleanly.
